// File: rtl/mar_address_sequencer_if.sv
// mar_address_sequencer_if: request handshake and MAR bus between the instruction FSM, the MAR and the sequencer
interface mar_address_sequencer_if;
    logic        start;
    logic        abort;
    logic [2:0]  mode;
    logic [15:0] PC;
    logic [7:0]  X;
    logic [7:0]  Y;
    logic [7:0]  DATA_IN;
    logic        load_MARH;
    logic        load_MARL;
    logic        reset_MAR;
    logic [7:0]  MAR_HIGH;
    logic [7:0]  MAR_LOW;
    logic        pc_inc;
    logic        busy;
    logic        done;
    logic [15:0] EA;
    logic        page_cross;
    modport master (
        output start, abort, mode, PC, X, Y, DATA_IN,
        input  load_MARH, load_MARL, reset_MAR, MAR_HIGH, MAR_LOW, pc_inc, busy, done, EA, page_cross
    );
    modport slave (
        input  start, abort, mode, PC, X, Y, DATA_IN,
        output load_MARH, load_MARL, reset_MAR, MAR_HIGH, MAR_LOW, pc_inc, busy, done, EA, page_cross
    );
endinterface

// File: rtl/mar_address_sequencer.sv
// mar_address_sequencer: 6502 addressing-mode sequencer driving the MAR and producing the effective address
module mar_address_sequencer (
    input  logic                          FSM_Signal,
    input  logic                          reset_ASEQ_n,
    mar_address_sequencer_if.slave        bus
);
    typedef enum logic [3:0] {IDLE, F1, R1, F2, R2, P1, R3, P2, R4, EAS} state_t;
    localparam logic [2:0] ZPX = 3'd1, ABSX = 3'd3, IND = 3'd4, INDX = 3'd5, INDY = 3'd6, IMM = 3'd7;
    state_t      state, nxt;
    logic [2:0]  mode_r, m;
    logic [7:0]  lo_r, idx;
    logic [15:0] ptr_r, ptr_n, base, ea_n, mar_n;
    logic [8:0]  lo_sum;
    logic        pcx_n, load, ab;
    always_comb begin
        m = (state == IDLE) ? bus.mode : mode_r;
        idx = (m == ZPX || m == ABSX) ? bus.X : (m == INDY) ? bus.Y : 8'h00;
        base = (state == R1) ? {8'h00, bus.DATA_IN} : {bus.DATA_IN, lo_r};
        lo_sum = {1'b0, base[7:0]} + {1'b0, idx};
        pcx_n = (m == ABSX || m == INDY) && lo_sum[8];
        ea_n = (state == IDLE) ? bus.PC : (m == ZPX) ? {8'h00, lo_sum[7:0]} : base + {8'h00, idx};
        ptr_n = (state == R2) ? {bus.DATA_IN, lo_r} : {8'h00, (m == INDX) ? bus.DATA_IN + bus.X : bus.DATA_IN};
        ab = bus.abort && state != IDLE;
        case (state)
            IDLE:    nxt = !bus.start ? IDLE : (m == IMM) ? EAS : F1;
            F1:      nxt = R1;
            R1:      nxt = (m <= ZPX) ? EAS : (m <= IND) ? F2 : P1;
            F2:      nxt = R2;
            R2:      nxt = (m == IND) ? P1 : EAS;
            P1:      nxt = R3;
            R3:      nxt = P2;
            P2:      nxt = R4;
            R4:      nxt = EAS;
            default: nxt = IDLE;
        endcase
        if (ab) nxt = IDLE;
        // second pointer fetch never carries into the high byte (6502 page-wrap)
        mar_n = (nxt == P1) ? ptr_n : (nxt == P2) ? {ptr_r[15:8], ptr_r[7:0] + 8'd1} : (nxt == EAS) ? ea_n : bus.PC;
        load = nxt inside {F1, F2, P1, P2, EAS};
    end
    always_ff @(posedge FSM_Signal or negedge reset_ASEQ_n) begin
        if (!reset_ASEQ_n) begin
            state          <= IDLE;
            mode_r         <= '0;
            lo_r           <= '0;
            ptr_r          <= '0;
            bus.busy       <= 1'b0;
            bus.load_MARH  <= 1'b0;
            bus.load_MARL  <= 1'b0;
            bus.reset_MAR  <= 1'b0;
            bus.pc_inc     <= 1'b0;
            bus.done       <= 1'b0;
            bus.MAR_HIGH   <= '0;
            bus.MAR_LOW    <= '0;
            bus.EA         <= '0;
            bus.page_cross <= 1'b0;
        end else begin
            state         <= nxt;
            bus.busy      <= nxt != IDLE;
            bus.load_MARH <= load;
            bus.load_MARL <= load;
            bus.reset_MAR <= ab;
            bus.pc_inc    <= nxt == F1 || nxt == F2 || (nxt == EAS && state == IDLE);
            bus.done      <= nxt == EAS;
            if (load) {bus.MAR_HIGH, bus.MAR_LOW} <= mar_n;
            if (state == IDLE && bus.start) mode_r <= bus.mode;
            if (state == R1 || state == R3) lo_r <= bus.DATA_IN;
            if (nxt == P1) ptr_r <= ptr_n;
            if (nxt == EAS) begin
                bus.EA         <= ea_n;
                bus.page_cross <= pcx_n;
            end
        end
    end
endmodule

// File: tb/tb_mar_address_sequencer.sv
// tb_mar_address_sequencer: directed checks of the address sequencer against a modelled MAR, PC and memory
module tb_mar_address_sequencer;
    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic [15:0] pc = 16'h0300;
    logic [15:0] mar = 16'h0000;
    logic [15:0] pc0;
    logic [7:0]  mem [0:65535];
    int          total = 0;
    int          bad = 0;
    int          lat;
    int          npc;
    logic        saw_done;

    mar_address_sequencer_if bus ();
    mar_address_sequencer dut (.FSM_Signal(clk), .reset_ASEQ_n(rst_n), .bus(bus));

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (bus.pc_inc) pc <= pc + 16'd1;
        if (bus.reset_MAR) mar <= 16'h0000;
        else begin
            if (bus.load_MARH) mar[15:8] <= bus.MAR_HIGH;
            if (bus.load_MARL) mar[7:0] <= bus.MAR_LOW;
        end
    end

    assign bus.PC = pc;
    assign bus.DATA_IN = mem[mar];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_reset(input string tag);
        chk({tag, "_strobes"}, {bus.busy, bus.load_MARH, bus.load_MARL, bus.reset_MAR, bus.pc_inc, bus.done}, 0);
        chk({tag, "_marbus"}, {bus.MAR_HIGH, bus.MAR_LOW}, 0);
        chk({tag, "_ea"}, bus.EA, 0);
        chk({tag, "_pcx"}, bus.page_cross, 0);
    endtask

    task automatic run_seq(input logic [2:0] m, output int l, output int n);
        bus.mode = m;
        bus.start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        bus.start = 1'b0;
        l = -1;
        n = 0;
        for (int c = 1; c <= 20; c++) begin
            if (bus.pc_inc) n++;
            if (bus.done) begin
                l = c;
                break;
            end
            @(negedge clk);
        end
    endtask

    initial begin
        bus.start = 1'b0;
        bus.abort = 1'b0;
        bus.mode = 3'd0;
        bus.X = 8'h00;
        bus.Y = 8'h00;
        for (int i = 0; i < 65536; i++) mem[i] = 8'h00;
        #1 rst_n = 1'b0;
        #1 chk_reset("rst");
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        bus.X = 8'h20;
        mem[pc] = 8'hF0;
        run_seq(3'd1, lat, npc);
        chk("zpx_lat", lat, 3);
        chk("zpx_ea", bus.EA, 16'h0010);
        chk("zpx_pcx", bus.page_cross, 0);
        chk("zpx_pcinc", npc, 1);
        @(negedge clk);
        chk("zpx_mar", mar, 16'h0010);
        chk("zpx_idle", {bus.busy, bus.done}, 0);

        bus.X = 8'h01;
        mem[pc] = 8'hFF;
        mem[pc + 16'd1] = 8'h12;
        run_seq(3'd3, lat, npc);
        chk("absx_lat", lat, 5);
        chk("absx_ea", bus.EA, 16'h1300);
        chk("absx_pcx", bus.page_cross, 1);
        chk("absx_pcinc", npc, 2);
        @(negedge clk);
        chk("absx_mar", mar, 16'h1300);

        mem[16'h02FF] = 8'h34;
        mem[16'h0200] = 8'h12;
        mem[16'h0300] = 8'h99;
        mem[pc] = 8'hFF;
        mem[pc + 16'd1] = 8'h02;
        run_seq(3'd4, lat, npc);
        chk("ind_lat", lat, 9);
        chk("ind_ea", bus.EA, 16'h1234);
        chk("ind_pcx", bus.page_cross, 0);
        chk("ind_pcinc", npc, 2);
        @(negedge clk);
        chk("ind_mar", mar, 16'h1234);

        bus.Y = 8'h90;
        mem[pc] = 8'hFF;
        mem[16'h00FF] = 8'h80;
        mem[16'h0000] = 8'h40;
        run_seq(3'd6, lat, npc);
        chk("indy_lat", lat, 7);
        chk("indy_ea", bus.EA, 16'h4110);
        chk("indy_pcx", bus.page_cross, 1);
        chk("indy_pcinc", npc, 1);
        @(negedge clk);
        chk("indy_mar", mar, 16'h4110);

        bus.X = 8'h05;
        mem[pc] = 8'h10;
        bus.mode = 3'd5;
        bus.start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        bus.start = 1'b0;
        saw_done = bus.done;
        @(negedge clk);
        bus.start = 1'b1;
        bus.mode = 3'd7;
        saw_done = saw_done | bus.done;
        @(negedge clk);
        bus.start = 1'b0;
        saw_done = saw_done | bus.done;
        chk("abort_p1_load", {bus.MAR_HIGH, bus.MAR_LOW, bus.load_MARH, bus.load_MARL}, {16'h0015, 2'b11});
        bus.abort = 1'b1;
        @(negedge clk);
        bus.abort = 1'b0;
        saw_done = saw_done | bus.done;
        chk("abort_pulse", {bus.reset_MAR, bus.busy}, 2'b10);
        chk("abort_ea", bus.EA, 16'h4110);
        chk("abort_pcx", bus.page_cross, 1);
        @(negedge clk);
        chk("abort_mar", mar, 16'h0000);
        chk("abort_nodone", {saw_done, bus.done, bus.busy, bus.reset_MAR}, 0);

        mem[pc] = 8'h34;
        mem[pc + 16'd1] = 8'h12;
        bus.mode = 3'd2;
        bus.start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        bus.start = 1'b0;
        @(negedge clk);
        @(negedge clk);
        @(negedge clk);
        chk("rmid_busy", bus.busy, 1);
        #2 rst_n = 1'b0;
        #1 chk_reset("rmid");
        rst_n = 1'b1;
        @(negedge clk);
        pc0 = pc;
        run_seq(3'd7, lat, npc);
        chk("imm_lat", lat, 1);
        chk("imm_ea", bus.EA, pc0);
        chk("imm_pcx", bus.page_cross, 0);
        chk("imm_pcinc", npc, 1);
        @(negedge clk);
        chk("imm_mar", mar, pc0);
        chk("imm_pc", pc, pc0 + 16'd1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/mar_address_sequencer.md
# mar_address_sequencer

Addressing-mode sequencer for the 6502 core's memory address register. On a start request from the instruction FSM, it fetches operand bytes through the MAR and, where the mode needs it, pointer bytes. It then loads the MAR with the final effective address. It is the only block that drives the MAR's load strobes and data inputs; the MAR is clocked by the same `FSM_Signal`.

## Interface
Parameters:
- none (the address width is fixed at 16 bits and the data width at 8 bits)

Ports:
- `FSM_Signal`  in  1  Clock. All state updates happen on its rising edge.
- `reset_ASEQ_n`  in  1  Asynchronous reset, active-low.
- `start`  in  1  Request to begin a sequence. It is sampled only in IDLE.
- `mode`  in  3  Addressing mode, latched at start: 0 ZP, 1 ZPX, 2 ABS, 3 ABSX, 4 IND, 5 INDX, 6 INDY, 7 IMM.
- `abort`  in  1  Synchronous cancel of the current sequence.
- `PC`  in  16  Program counter. It must reflect a `pc_inc` by the cycle after the pulse.
- `X`, `Y`  in  8 each  Index registers, sampled when used.
- `DATA_IN`  in  8  Memory read data for the current `OUT_MAR`. Valid in the cycle after a MAR load.
- `load_MARH`, `load_MARL`  out  1 each  MAR byte load strobes.
- `reset_MAR`  out  1  MAR synchronous clear strobe.
- `MAR_HIGH`, `MAR_LOW`  out  8 each  Values driven to the MAR's `IN_HIGH` and `IN_LOW` inputs.
- `pc_inc`  out  1  One-cycle request to increment the PC.
- `busy`  out  1  High in every state except IDLE.
- `done`  out  1  One-cycle pulse when the effective address is loaded.
- `EA`  out  16  Effective address. It is held from `done` until the next `done`.
- `page_cross`  out  1  Carry out of the low byte during ABSX/INDY indexing. It is valid with `done` and held with `EA`.

## Operation
- States: IDLE, F1, R1, F2, R2, P1, R3, P2, R4, EAS.
- Internal registers: `lo_r`, `hi_r`, `ptr_r`, and the latched mode.
- Outputs are decoded from the state and these registers (Moore); they are not combinational from the inputs.
- IDLE:
  - On `start`=1, latch the mode.
  - Go to EAS if the mode is IMM, otherwise to F1.
- F1/F2:
  - Drive `MAR_HIGH`/`MAR_LOW` = `PC`.
  - Assert both loads and `pc_inc`.
  - F1 goes to R1; F2 goes to R2.
- R1:
  - Set `lo_r` = `DATA_IN`.
  - ZP/ZPX go to EAS. ABS/ABSX/IND go to F2. INDX/INDY go to P1.
  - For INDX, `ptr_r` = (`DATA_IN`+`X`) mod 256. For INDY, `ptr_r` = `DATA_IN`.
- R2:
  - Set `hi_r` = `DATA_IN`.
  - IND goes to P1 with `ptr` = {`hi_r`,`lo_r`}. Others go to EAS.
- P1:
  - Load MAR = {00,`ptr_r`} for INDX/INDY, or {`hi_r`,`lo_r`} for IND.
  - Go to R3.
- R3:
  - Capture the pointer's low byte into `lo_r`.
  - Go to P2.
- P2:
  - Load MAR = {00,(`ptr_r`+1) mod 256}.
  - For IND, load MAR = {original `hi_r`,(original `lo_r`+1) mod 256}. This reproduces the 6502 page-wrap bug: there is no carry into the high byte.
  - The IND pointer bytes are held in `ptr` copies so that R3 does not corrupt them.
- R4:
  - Set `hi_r` = `DATA_IN`.
  - Go to EAS.
- EAS:
  - Load MAR with the effective address, set `EA`, and pulse `done`.
  - Always go to IDLE next.
- Effective address by mode:
  - ZP: {00,`lo`}.
  - ZPX: {00,(`lo`+`X`) mod 256}.
  - ABS, IND, INDX: {`hi`,`lo`}.
  - ABSX: {`hi`,`lo`}+`X` (16-bit, wraps at FFFF). `page_cross` = carry out of `lo`+`X`.
  - INDY: {`hi`,`lo`}+`Y`, with `page_cross` computed the same way.
  - IMM: `PC`, with `pc_inc` asserted in EAS.
  - Modes without indexing clear `page_cross` at `done`.
- `start` while `busy` is ignored. It is not queued.
- `abort` has priority in any non-IDLE state: the block asserts `reset_MAR` for that cycle, goes to IDLE, and does not assert `done`. `EA` and `page_cross` keep their previous values.

## Timing
- Reset values:
  - State = IDLE.
  - All strobes (`load_MARH`, `load_MARL`, `reset_MAR`, `pc_inc`, `done`) = 0.
  - `busy` = 0.
  - `MAR_HIGH`/`MAR_LOW` = 00.
  - `EA` = 0000, `page_cross` = 0.
  - Internal registers = 0.
- Reset is asynchronous. Asserting it mid-sequence immediately forces the reset values.
- Latency counts cycles from the edge sampling `start` to the cycle containing `done`:
  - IMM: 1.
  - ZP/ZPX: 3.
  - ABS/ABSX: 5.
  - INDX/INDY: 7.
  - IND: 9.
- `OUT_MAR` equals `EA` one edge after the `done` cycle.
- The earliest next `start` is accepted in the cycle after `done`.
- `busy` rises with the first non-IDLE state and falls in the cycle after `done`.

## Test plan
- **ZPX wrap**: `mode`=1, operand 0xF0, `X`=0x20 -> `done` at cycle 3, `EA`=0x0010, `page_cross`=0, exactly one `pc_inc`.
- **ABSX page cross**: `mode`=3, operand bytes 0xFF then 0x12, `X`=0x01 -> `EA`=0x1300, `page_cross`=1, two `pc_inc` pulses, `done` at cycle 5.
- **IND page bug**: `mode`=4, operand 0x02FF, `mem[02FF]`=0x34, `mem[0200]`=0x12 -> `EA`=0x1234 (not `mem[0300]`), `done` at cycle 9.
- **INDY**: `mode`=6, operand 0xFF, `mem[00FF]`=0x80, `mem[0000]`=0x40, `Y`=0x90 -> the pointer high byte is read from 0x0000, `EA`=0x4110, `page_cross`=1.
- **abort**: `abort` in P1 of INDX -> `reset_MAR` pulse, `OUT_MAR`=0000 next edge, no `done`, `EA` keeps its previous value; a `start` during `busy` is shown to be ignored.
- **Reset mid-sequence**: `reset_ASEQ_n` low during R2 -> all outputs at their reset values without a clock edge; a following IMM `start` gives `done` at cycle 1 with `EA`=`PC`.
